// File: rtl/galaksija_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module   : galaksija_keymatrix
//  Purpose  : Turns hps_io ps2_key events into the Galaksija 64-key matrix
//             that the Z80 reads at 0x2000-0x203F. Makes apply at once.
//             A release that comes too soon after its make is held back
//             until MIN_HOLD cycles have passed, so a short keypress is
//             still seen by the firmware scan loop.
//  Revision : 1.0 - initial release
// ============================================================================
module galaksija_keymatrix #(
   parameter int MIN_HOLD = 125000,
   parameter int CNT_W    = 17
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [5:0]  kbd_addr,
   output logic [7:0]  kbd_dout,
   output logic        key_break
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_HOLD - 1);
   localparam logic [5:0]       IDX_SHIFT = 6'h35;
   localparam logic [5:0]       IDX_BRK   = 6'h31;

   logic [63:0]      pressed, pend;
   logic             lsh, rsh, prev_tog, tmr_run;
   logic [5:0]       last_key;
   logic [CNT_W-1:0] timer;

   logic [63:0]      pressed_n, pend_n;
   logic             lsh_n, rsh_n, tmr_run_n;
   logic [5:0]       last_key_n;
   logic [CNT_W-1:0] timer_n;

   logic             evt, is_make, expire;
   logic [5:0]       idx;
   logic             is_lsh, is_rsh;
   logic [63:0]      view;

   assign evt     = ps2_key[10] != prev_tog;
   assign is_make = ps2_key[9];
   assign expire  = tmr_run && (timer == HOLD_LAST);

   // Scancode (with E0 flag) to matrix index; idx 0 means "no key".
   always_comb begin
      idx    = 6'h00;
      is_lsh = 1'b0;
      is_rsh = 1'b0;
      case (ps2_key[8:0])
         9'h01C: idx = 6'h01;  9'h032: idx = 6'h02;  9'h021: idx = 6'h03;
         9'h023: idx = 6'h04;  9'h024: idx = 6'h05;  9'h02B: idx = 6'h06;
         9'h034: idx = 6'h07;  9'h033: idx = 6'h08;  9'h043: idx = 6'h09;
         9'h03B: idx = 6'h0A;  9'h042: idx = 6'h0B;  9'h04B: idx = 6'h0C;
         9'h03A: idx = 6'h0D;  9'h031: idx = 6'h0E;  9'h044: idx = 6'h0F;
         9'h04D: idx = 6'h10;  9'h015: idx = 6'h11;  9'h02D: idx = 6'h12;
         9'h01B: idx = 6'h13;  9'h02C: idx = 6'h14;  9'h03C: idx = 6'h15;
         9'h02A: idx = 6'h16;  9'h01D: idx = 6'h17;  9'h022: idx = 6'h18;
         9'h035: idx = 6'h19;  9'h01A: idx = 6'h1A;
         9'h175: idx = 6'h1B;  9'h172: idx = 6'h1C;  9'h16B: idx = 6'h1D;
         9'h174: idx = 6'h1E;  9'h029: idx = 6'h1F;
         9'h045: idx = 6'h20;  9'h016: idx = 6'h21;  9'h01E: idx = 6'h22;
         9'h026: idx = 6'h23;  9'h025: idx = 6'h24;  9'h02E: idx = 6'h25;
         9'h036: idx = 6'h26;  9'h03D: idx = 6'h27;  9'h03E: idx = 6'h28;
         9'h046: idx = 6'h29;
         9'h04C: idx = 6'h2A;  9'h052: idx = 6'h2B;  9'h041: idx = 6'h2C;
         9'h055: idx = 6'h2D;  9'h049: idx = 6'h2E;  9'h04A: idx = 6'h2F;
         9'h05A: idx = 6'h30;  9'h076: idx = 6'h31;  9'h00D: idx = 6'h32;
         9'h066: idx = 6'h33;  9'h005: idx = 6'h34;
         9'h012: is_lsh = 1'b1;
         9'h059: is_rsh = 1'b1;
         default: idx = 6'h00;
      endcase
   end

   // Next-state: hold-timer expiry first, then the event overrides its own bit.
   always_comb begin
      pressed_n  = pressed;
      pend_n     = pend;
      lsh_n      = lsh;
      rsh_n      = rsh;
      tmr_run_n  = tmr_run;
      last_key_n = last_key;
      timer_n    = timer;

      if (tmr_run) begin
         if (expire) begin
            pressed_n = pressed & ~pend;
            pend_n    = '0;
            tmr_run_n = 1'b0;
         end else begin
            timer_n = timer + 1'b1;
         end
      end

      if (evt) begin
         if (is_lsh) begin
            lsh_n = is_make;
         end else if (is_rsh) begin
            rsh_n = is_make;
         end else if (idx != 6'h00) begin
            if (is_make) begin
               pressed_n[idx] = 1'b1;
               pend_n[idx]    = 1'b0;
               last_key_n     = idx;
               timer_n        = '0;
               tmr_run_n      = 1'b1;
            end else if (tmr_run && !expire && (idx == last_key)) begin
               // Too-short press: keep it visible until the timer expires.
               pend_n[idx] = 1'b1;
            end else begin
               pressed_n[idx] = 1'b0;
               pend_n[idx]    = 1'b0;
            end
         end
      end
   end

   // Key state registers; a toggle seen during reset is absorbed, not processed.
   always_ff @(posedge clk_sys) begin
      prev_tog <= ps2_key[10];
      if (reset) begin
         pressed  <= '0;
         pend     <= '0;
         lsh      <= 1'b0;
         rsh      <= 1'b0;
         tmr_run  <= 1'b0;
         last_key <= 6'h00;
         timer    <= '0;
      end else begin
         pressed  <= pressed_n;
         pend     <= pend_n;
         lsh      <= lsh_n;
         rsh      <= rsh_n;
         tmr_run  <= tmr_run_n;
         last_key <= last_key_n;
         timer    <= timer_n;
      end
   end

   // Matrix as seen by the CPU: shift merged in, unused indices forced idle.
   always_comb begin
      view            = pressed;
      view[IDX_SHIFT] = lsh | rsh;
      view[0]         = 1'b0;
      view[63:54]     = '0;
   end

   // Registered CPU read port and break level.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         kbd_dout  <= 8'hFF;
         key_break <= 1'b0;
      end else begin
         kbd_dout  <= view[kbd_addr] ? 8'hFE : 8'hFF;
         key_break <= pressed[IDX_BRK];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_galaksija_keymatrix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_galaksija_keymatrix
//  Purpose  : Directed bench for galaksija_keymatrix with an event-time
//             reference model and literal spot checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_galaksija_keymatrix;

   localparam int MIN_HOLD = 20;
   localparam int CNT_W    = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [5:0]  kbd_addr;
   logic [7:0]  kbd_dout;
   logic        key_break;

   int checks = 0;
   int errors = 0;
   logic tog = 1'b0;
   logic check_en = 1'b0;

   galaksija_keymatrix #(.MIN_HOLD(MIN_HOLD), .CNT_W(CNT_W)) dut (
      .clk_sys   (clk),
      .reset     (reset),
      .ps2_key   (ps2_key),
      .kbd_addr  (kbd_addr),
      .kbd_dout  (kbd_dout),
      .key_break (key_break)
   );

   always #5 clk = ~clk;

   // Key table: entry i is the {E0, scancode} that maps to matrix index i.
   logic [8:0] keytab [1:52];
   initial begin
      keytab = '{9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034, 9'h033,
                 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044, 9'h04D,
                 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D, 9'h022,
                 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h045,
                 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D, 9'h03E,
                 9'h046, 9'h04C, 9'h052, 9'h041, 9'h055, 9'h049, 9'h04A, 9'h05A,
                 9'h076, 9'h00D, 9'h066, 9'h005};
   end

   // Reference model: keys down, releases waiting for the hold window,
   // and the cycle of the most recent make.
   bit         m_down [64];
   bit         m_wait [64];
   bit         m_lsh, m_rsh, m_prev, m_have_make;
   int         m_last_key, m_make_cyc, cyc;
   logic [7:0] exp_dout;
   logic       exp_brk;

   function automatic bit m_view(input int a);
      if (a == 0 || a > 'h35) return 1'b0;
      if (a == 'h35) return m_lsh | m_rsh;
      return m_down[a];
   endfunction

   always @(posedge clk) begin
      int k;
      if (reset) begin
         foreach (m_down[i]) begin m_down[i] = 0; m_wait[i] = 0; end
         m_lsh = 0; m_rsh = 0; m_have_make = 0; m_last_key = 0;
         m_prev   = ps2_key[10];
         exp_dout = 8'hFF;
         exp_brk  = 1'b0;
      end else begin
         exp_dout = m_view(int'(kbd_addr)) ? 8'hFE : 8'hFF;
         exp_brk  = m_down['h31];
         // Hold window ends exactly MIN_HOLD cycles after the latest make.
         if (m_have_make && cyc == m_make_cyc + MIN_HOLD) begin
            foreach (m_wait[i]) if (m_wait[i]) begin m_down[i] = 0; m_wait[i] = 0; end
            m_have_make = 0;
         end
         if (ps2_key[10] != m_prev) begin
            k = 0;
            for (int i = 1; i <= 52; i++) if (keytab[i] == ps2_key[8:0]) k = i;
            if (ps2_key[8:0] == 9'h012)      m_lsh = ps2_key[9];
            else if (ps2_key[8:0] == 9'h059) m_rsh = ps2_key[9];
            else if (k != 0) begin
               if (ps2_key[9]) begin
                  m_down[k] = 1; m_wait[k] = 0;
                  m_last_key = k; m_make_cyc = cyc; m_have_make = 1;
               end else if (m_have_make && k == m_last_key) begin
                  m_wait[k] = 1;
               end else begin
                  m_down[k] = 0; m_wait[k] = 0;
               end
            end
         end
         m_prev = ps2_key[10];
      end
      cyc++;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (check_en) begin
         checks++;
         if (kbd_dout !== exp_dout || key_break !== exp_brk) begin
            errors++;
            $display("FAIL model t=%0t addr=%0h dout=%h exp=%h brk=%b exp=%b",
                     $time, kbd_addr, kbd_dout, exp_dout, key_break, exp_brk);
         end
      end
   end

   task automatic lit(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic mk, input logic ext, input logic [7:0] code);
      tog = ~tog;
      ps2_key = {tog, mk, ext, code};
      @(negedge clk);
   endtask

   task automatic sweep();
      for (int a = 0; a < 64; a++) begin
         kbd_addr = 6'(a);
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; ps2_key = '0; kbd_addr = 6'h01;
      @(negedge clk);
      check_en = 1'b1;
      wait_cyc(2);
      lit("reset_dout", kbd_dout, 8'hFF);
      lit("reset_brk", {7'b0, key_break}, 8'h00);
      reset = 1'b0;
      wait_cyc(2);

      // 1: make A, read back, scan all indices
      send(1'b1, 1'b0, 8'h1C);
      wait_cyc(1);
      lit("make_A", kbd_dout, 8'hFE);
      sweep();
      wait_cyc(MIN_HOLD);
      kbd_addr = 6'h01;
      send(1'b0, 1'b0, 8'h1C);
      wait_cyc(1);
      lit("late_break_A", kbd_dout, 8'hFF);

      // 2: short press is stretched to MIN_HOLD
      send(1'b1, 1'b0, 8'h1C);
      wait_cyc(9);
      send(1'b0, 1'b0, 8'h1C);
      wait_cyc(2);
      lit("short_press_held", kbd_dout, 8'hFE);
      wait_cyc(MIN_HOLD);
      lit("short_press_released", kbd_dout, 8'hFF);

      // 3: left and right shift tracked independently
      kbd_addr = 6'h35;
      send(1'b1, 1'b0, 8'h12);
      send(1'b1, 1'b0, 8'h59);
      send(1'b0, 1'b0, 8'h12);
      wait_cyc(1);
      lit("shift_rsh_held", kbd_dout, 8'hFE);
      send(1'b0, 1'b0, 8'h59);
      wait_cyc(1);
      lit("shift_released", kbd_dout, 8'hFF);

      // 4: E0 prefix required for cursor keys
      kbd_addr = 6'h1B;
      send(1'b1, 1'b1, 8'h75);
      wait_cyc(1);
      lit("e0_up", kbd_dout, 8'hFE);
      send(1'b1, 1'b0, 8'h75);
      sweep();
      send(1'b0, 1'b1, 8'h75);
      wait_cyc(2);

      // 5: break of a non-last key clears immediately
      send(1'b1, 1'b0, 8'h1C);
      send(1'b1, 1'b0, 8'h32);
      wait_cyc(2);
      kbd_addr = 6'h01;
      send(1'b0, 1'b0, 8'h1C);
      wait_cyc(1);
      lit("nonlast_break", kbd_dout, 8'hFF);
      kbd_addr = 6'h02;
      wait_cyc(1);
      lit("b_still_down", kbd_dout, 8'hFE);
      send(1'b0, 1'b0, 8'h32);
      wait_cyc(MIN_HOLD + 2);

      // Make landing on the expiry cycle; pending A cleared, new B kept
      send(1'b1, 1'b0, 8'h1C);
      send(1'b0, 1'b0, 8'h1C);
      wait_cyc(MIN_HOLD - 2);
      send(1'b1, 1'b0, 8'h32);
      sweep();
      // Break of last_key landing exactly on expiry clears at once
      send(1'b1, 1'b0, 8'h32);
      wait_cyc(MIN_HOLD - 1);
      send(1'b0, 1'b0, 8'h32);
      wait_cyc(1);
      lit("break_on_expiry", kbd_dout, 8'hFF);

      // 6: BRK level, then reset mid-hold with an unchanged toggle
      kbd_addr = 6'h31;
      send(1'b1, 1'b0, 8'h76);
      wait_cyc(1);
      lit("brk_level", {7'b0, key_break}, 8'h01);
      wait_cyc(3);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      wait_cyc(2);
      lit("reset_mid_brk", {7'b0, key_break}, 8'h00);
      lit("reset_mid_dout", kbd_dout, 8'hFF);
      // A toggle during reset is discarded
      kbd_addr = 6'h01;
      reset = 1'b1;
      send(1'b1, 1'b0, 8'h1C);
      reset = 1'b0;
      wait_cyc(3);
      lit("evt_in_reset", kbd_dout, 8'hFF);
      wait_cyc(MIN_HOLD);

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
